seq_multiplier: RTL

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//
// Sequential shift-and-add multiplier. One multiplier bit is consumed per
// clock, LSB first, so a product takes WIDTH cycles after the start edge.
//
// Parameters
//   WIDTH        operand width in bits (2..32), default 4
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        operation request, only sampled while idle
//   a            multiplicand, captured at the accepted start
//   b            multiplier, captured at the accepted start
//   signed_mode  (only with SEQ_MULT_SIGNED_EN) 1 = two's complement operands
//   busy         high while the product is being accumulated
//   done         one-cycle pulse when result carries a new product
//   result       registered 2*WIDTH-bit product, held until the next done
//
// Optional feature
//   SEQ_MULT_SIGNED_EN  when defined, adds the signed_mode port and the
//                       signed (sign-extend + subtract MSB term) datapath.
// ---------------------------------------------------------------------------
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int PW = 2 * WIDTH;
  // One extra bit so the counter can represent WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [PW-1:0]   mcand_r;    // multiplicand, already extended to PW bits
  logic [WIDTH-1:0] mplier_r;  // multiplier as captured
  logic [PW-1:0]   acc_r;
  logic [CW-1:0]   cnt_r;
`ifdef SEQ_MULT_SIGNED_EN
  logic            signed_r;
`endif

  logic [WIDTH-1:0] mplier_sh_s;
  logic             cur_bit_s;
  logic             last_s;
  logic [PW-1:0]    pp_s;
  logic [PW-1:0]    acc_next_s;
  logic [PW-1:0]    mcand_ext_s;

  // Extension of the incoming multiplicand; sign-extend only in signed mode.
  always_comb begin
    mcand_ext_s = {{WIDTH{1'b0}}, a};
`ifdef SEQ_MULT_SIGNED_EN
    if (signed_mode) begin
      mcand_ext_s = {{WIDTH{a[WIDTH-1]}}, a};
    end else begin
      mcand_ext_s = {{WIDTH{1'b0}}, a};
    end
`endif
  end

  // Partial product for the current iteration and the next accumulator value.
  always_comb begin
    // Shifting instead of indexing keeps the index width independent of CW.
    mplier_sh_s = mplier_r >> cnt_r;
    cur_bit_s   = mplier_sh_s[0];
    last_s      = (cnt_r == CW'(WIDTH - 1));
    if (cur_bit_s) begin
      pp_s = mcand_r << cnt_r;
    end else begin
      pp_s = {PW{1'b0}};
    end
`ifdef SEQ_MULT_SIGNED_EN
    // In two's complement the MSB of the multiplier has negative weight.
    if (signed_r && last_s) begin
      acc_next_s = acc_r - pp_s;
    end else begin
      acc_next_s = acc_r + pp_s;
    end
`else
    acc_next_s = acc_r + pp_s;
`endif
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      mcand_r  <= {PW{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {PW{1'b0}};
      cnt_r    <= {CW{1'b0}};
`ifdef SEQ_MULT_SIGNED_EN
      signed_r <= 1'b0;
`endif
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= {PW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand_r  <= mcand_ext_s;
            mplier_r <= b;
`ifdef SEQ_MULT_SIGNED_EN
            signed_r <= signed_mode;
`endif
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy     <= 1'b1;
            state_r  <= CALC;
          end else begin
            busy     <= 1'b0;
          end
        end
        CALC: begin
          // No early exit: zero operands still run all WIDTH iterations.
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            result  <= acc_next_s;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end else begin
            busy    <= 1'b1;
          end
        end
        DONE: begin
          // start is deliberately not looked at here.
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
